// File: rtl/core_pkg.sv
// Shared pipeline definitions: sequencer states, stage indices and the NOP used on flush.
// Stage indices name the register each enable loads (IF = PC, ID = IF/ID, ...).
package core_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        MWAIT = 2'd2
    } state_e;

    localparam int STG_IF   = 0;
    localparam int STG_ID   = 1;
    localparam int STG_IE   = 2;
    localparam int STG_IMEM = 3;
    localparam int STG_WB   = 4;
    localparam int STG_NUM  = 5;

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    // Pipeline registers load the NOP whenever flush is raised, regardless of enable.
    function automatic logic [31:0] stage_insn(input logic flush, input logic [31:0] insn);
        return flush ? NOP_INSN : insn;
    endfunction

endpackage

// File: rtl/stall_watchdog.sv
// Stall watchdog: saturating count of consecutive stall cycles plus a sticky timeout flag.
// Latency: flag registered, visible the cycle after the MAX_STALL-th stall; no backpressure.
// Cleared only by synchronous reset; any non-stall cycle clears the count but not the flag.
module stall_watchdog #(
    parameter int MAX_STALL = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic stall,
    output logic stall_timeout
);

    localparam logic [7:0] MAX_CNT = 8'(MAX_STALL);

    logic [7:0] stall_cnt_q, stall_cnt_d;
    logic       timeout_q, timeout_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        timeout_d   = timeout_q;
        if (!stall) begin
            stall_cnt_d = 8'd0;
        end else if (stall_cnt_q != MAX_CNT) begin
            stall_cnt_d = stall_cnt_q + 8'd1;
        end
        if (stall_cnt_d == MAX_CNT) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= 8'd0;
            timeout_q   <= 1'b0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    assign stall_timeout = timeout_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// 5-stage pipeline sequencer: prioritised stall/flush merge, branch flush FSM, watchdog.
// Latency: enables/flushes combinational (same-cycle stall); state and counters registered.
// Backpressure: dmem_busy freezes every stage; PIPE_HAZARD_PERF_EN adds perf counters.
module pipe_hazard_ctrl
    import core_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int MAX_STALL    = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        br_stall,
    input  logic        lu_stall,
    input  logic        branch_taken,
    input  logic        imem_ready,
    input  logic        dmem_busy,
    output logic        pc_en,
    output logic        if_id_en,
    output logic        id_ie_en,
    output logic        ie_imem_en,
    output logic        imem_wb_en,
    output logic        if_id_flush,
    output logic        id_ie_flush,
    output logic        stall_timeout
`ifdef PIPE_HAZARD_PERF_EN
    ,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt,
    output logic [31:0] perf_mwait_cnt
`endif
);

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    state_e             state_q, state_d;
    logic [2:0]         cnt_q, cnt_d;
    logic               in_flush;
    logic [STG_NUM-1:0] stage_en;

    // MWAIT keeps the frozen count, so leaving it resumes the flush when one is pending.
    assign in_flush = (state_q != RUN) && (cnt_q != 3'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = RUN;
        cnt_d   = cnt_q;
        if (dmem_busy) begin
            state_d = MWAIT;
        end else if (branch_taken) begin
            cnt_d   = FLUSH_LOAD;
            state_d = (FLUSH_LOAD != 3'd0) ? FLUSH : RUN;
        end else if (in_flush) begin
            cnt_d   = cnt_q - 3'd1;
            state_d = (cnt_d != 3'd0) ? FLUSH : RUN;
        end
    end

    always_comb begin
        stage_en    = '1;
        if_id_flush = 1'b0;
        id_ie_flush = 1'b0;
        if (rst) begin
            stage_en    = '0;
            if_id_flush = 1'b1;
            id_ie_flush = 1'b1;
        end else if (dmem_busy) begin
            stage_en = '0;
        end else if (branch_taken) begin
            if_id_flush = 1'b1;
            id_ie_flush = 1'b1;
        end else if (in_flush) begin
            // ID already holds a bubble, so hazard requests are moot here.
            if_id_flush = 1'b1;
        end else if (br_stall || lu_stall) begin
            stage_en[STG_IF] = 1'b0;
            stage_en[STG_ID] = 1'b0;
            id_ie_flush      = 1'b1;
        end else if (!imem_ready) begin
            stage_en[STG_IF] = 1'b0;
            if_id_flush      = 1'b1;
        end
    end

    assign pc_en      = stage_en[STG_IF];
    assign if_id_en   = stage_en[STG_ID];
    assign id_ie_en   = stage_en[STG_IE];
    assign ie_imem_en = stage_en[STG_IMEM];
    assign imem_wb_en = stage_en[STG_WB];

    stall_watchdog #(
        .MAX_STALL (MAX_STALL)
    ) u_stall_watchdog (
        .clk           (clk),
        .rst           (rst),
        .stall         (~pc_en),
        .stall_timeout (stall_timeout)
    );

`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_flush_q, perf_flush_d;
    logic [31:0] perf_mwait_q, perf_mwait_d;

    always_comb begin
        perf_stall_d = perf_stall_q + {31'd0, ~pc_en};
        perf_flush_d = perf_flush_q + {31'd0, if_id_flush};
        perf_mwait_d = perf_mwait_q + {31'd0, dmem_busy};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_q <= 32'd0;
            perf_flush_q <= 32'd0;
            perf_mwait_q <= 32'd0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
            perf_mwait_q <= perf_mwait_d;
        end
    end

    assign perf_stall_cnt = perf_stall_q;
    assign perf_flush_cnt = perf_flush_q;
    assign perf_mwait_cnt = perf_mwait_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl (FLUSH_CYCLES=3, MAX_STALL=64): per-cycle behavioural model compare
// at negedge plus hand-computed literal checks taken mid-cycle by the directed stimulus.
module tb_pipe_hazard_ctrl;

    localparam int FLUSH_CYCLES = 3;
    localparam int MAX_STALL    = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic br_stall = 1'b0, lu_stall = 1'b0, branch_taken = 1'b0;
    logic imem_ready = 1'b1, dmem_busy = 1'b0;
    logic pc_en, if_id_en, id_ie_en, ie_imem_en, imem_wb_en;
    logic if_id_flush, id_ie_flush, stall_timeout;
`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] perf_stall_cnt, perf_flush_cnt, perf_mwait_cnt;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(
        .FLUSH_CYCLES (FLUSH_CYCLES),
        .MAX_STALL    (MAX_STALL)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .br_stall      (br_stall),
        .lu_stall      (lu_stall),
        .branch_taken  (branch_taken),
        .imem_ready    (imem_ready),
        .dmem_busy     (dmem_busy),
        .pc_en         (pc_en),
        .if_id_en      (if_id_en),
        .id_ie_en      (id_ie_en),
        .ie_imem_en    (ie_imem_en),
        .imem_wb_en    (imem_wb_en),
        .if_id_flush   (if_id_flush),
        .id_ie_flush   (id_ie_flush),
        .stall_timeout (stall_timeout)
`ifdef PIPE_HAZARD_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt),
        .perf_mwait_cnt (perf_mwait_cnt)
`endif
    );

    // {pc, if_id, id_ie, ie_imem, imem_wb enables, if_id_flush, id_ie_flush, stall_timeout}
    function automatic logic [7:0] dut_vec();
        return {pc_en, if_id_en, id_ie_en, ie_imem_en, imem_wb_en,
                if_id_flush, id_ie_flush, stall_timeout};
    endfunction

    // Model: pending flush cycles, consecutive stalls, sticky timeout, perf totals.
    int          m_pend  = 0;
    int          m_stall = 0;
    logic        m_to    = 1'b0;
    int unsigned m_pstall = 0, m_pflush = 0, m_pmwait = 0;
    logic        chk_en  = 1'b0;

    function automatic logic [7:0] rule_vec(input int rule);
        case (rule)
            1:       return 8'b00000_00_0;
            2:       return 8'b11111_11_0;
            3:       return 8'b11111_10_0;
            4:       return 8'b00111_01_0;
            5:       return 8'b01111_10_0;
            default: return 8'b11111_00_0;
        endcase
    endfunction

    always @(negedge clk) begin
        logic [7:0] exp;
        logic [7:0] got;
        int         rule;
        rule = 6;
        if (dmem_busy)                 rule = 1;
        else if (branch_taken)         rule = 2;
        else if (m_pend > 0)           rule = 3;
        else if (br_stall || lu_stall) rule = 4;
        else if (!imem_ready)          rule = 5;
        exp = rst ? {7'b00000_11, m_to} : (rule_vec(rule) | {7'd0, m_to});
        got = dut_vec();
        if (chk_en) begin
            n_cmp++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL model_cycle t=%0t: got %b want %b", $time, got, exp);
            end
`ifdef PIPE_HAZARD_PERF_EN
            n_cmp++;
            if (perf_stall_cnt !== m_pstall || perf_flush_cnt !== m_pflush ||
                perf_mwait_cnt !== m_pmwait) begin
                n_fail++;
                $display("FAIL model_perf t=%0t: got %0d/%0d/%0d want %0d/%0d/%0d", $time,
                         perf_stall_cnt, perf_flush_cnt, perf_mwait_cnt,
                         m_pstall, m_pflush, m_pmwait);
            end
`endif
        end
        if (rst) begin
            m_pend = 0; m_stall = 0; m_to = 1'b0;
            m_pstall = 0; m_pflush = 0; m_pmwait = 0;
            chk_en = 1'b1;
        end else begin
            if (rule == 2)      m_pend = FLUSH_CYCLES - 1;
            else if (rule == 3) m_pend = m_pend - 1;
            if (exp[7]) m_stall = 0;
            else if (m_stall < MAX_STALL) m_stall = m_stall + 1;
            if (m_stall == MAX_STALL) m_to = 1'b1;
            if (!exp[7]) m_pstall++;
            if (exp[2])  m_pflush++;
            if (rule == 1) m_pmwait++;
        end
    end

    task automatic drive(input logic r, input logic bs, input logic ls, input logic bt,
                         input logic ir, input logic db);
        @(posedge clk);
        #1;
        rst = r; br_stall = bs; lu_stall = ls; branch_taken = bt;
        imem_ready = ir; dmem_busy = db;
        #2;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic lit(input string name, input logic [7:0] exp);
        logic [7:0] got;
        got = dut_vec();
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b want %b", name, got, exp);
        end
    endtask

    initial begin
        // reset, then idle
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        lit("reset_hold", 8'b00000_11_0);
        idle();
        lit("idle_after_reset", 8'b11111_00_0);

        // load-use stall for two cycles
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0); lit("lu_stall_c1", 8'b00111_01_0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0); lit("lu_stall_c2", 8'b00111_01_0);
        idle();                                    lit("lu_stall_done", 8'b11111_00_0);

        // branch redirect, br_stall ignored while flushing, honoured once back in RUN
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0); lit("branch_c0", 8'b11111_11_0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0); lit("flush_c1", 8'b11111_10_0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0); lit("flush_c2", 8'b11111_10_0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0); lit("run_after_flush", 8'b00111_01_0);
        idle();

        // branch, one flush cycle, then dmem_busy freezes the remaining flush
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0); lit("branch_mw_c0", 8'b11111_11_0);
        idle();                                    lit("branch_mw_c1", 8'b11111_10_0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
            lit("mwait_frozen", 8'b00000_00_0);
        end
        idle();                                    lit("mwait_resume_flush", 8'b11111_10_0);
        idle();                                    lit("mwait_back_run", 8'b11111_00_0);

        // imem not ready for 70 cycles: watchdog trips after 64 stall cycles
        for (int i = 1; i <= 70; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            if (i == 1)  lit("imem_wait_c1", 8'b01111_10_0);
            if (i == 64) lit("wd_before_trip", 8'b01111_10_0);
            if (i == 65) lit("wd_tripped", 8'b01111_10_1);
        end
        idle();                                    lit("wd_sticky_run", 8'b11111_00_1);
        idle();

        // dmem_busy beats branch_taken and lu_stall in the same cycle
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1); lit("mwait_wins", 8'b00000_00_1);

        // reset clears the sticky flag one edge later
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); lit("rst_c1_sticky", 8'b00000_11_1);
`ifdef PIPE_HAZARD_PERF_EN
        n_cmp++;
        if (perf_mwait_cnt !== 32'd5) begin
            n_fail++;
            $display("FAIL perf_mwait_total: got %0d want 5", perf_mwait_cnt);
        end
`endif
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); lit("rst_c2_cleared", 8'b00000_11_0);
        idle();                                    lit("post_rst_run", 8'b11111_00_0);

        // reset mid-FLUSH
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle();                                    lit("rst_mid_flush", 8'b11111_00_0);

        // reset mid-MWAIT with a pending flush
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle();                                    lit("rst_mid_mwait", 8'b11111_00_0);
        idle();
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central pipeline sequencer for the 5-stage core (IF, ID, IE, IMEM, WB).
- Merges the stall requests into one prioritised decision per cycle: data-hazard stall from the ID-stage stall logic, load-use stall, branch redirect, instruction-memory wait and data-memory wait.
- Drives every stage-register enable and flush.
- Owns the multi-cycle branch flush sequence and a stall watchdog.

Parameters:
- FLUSH_CYCLES, 2: cycles IF/ID is flushed after a redirect, counting the redirect cycle. Legal range 1..7.
- MAX_STALL, 64: consecutive stall cycles before `stall_timeout` is raised. Legal range 2..255.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-high
- br_stall  in  1  RAW stall request for a branch/compare in ID
- lu_stall  in  1  load-use stall request (load in IE, consumer in ID)
- branch_taken  in  1  IE resolved a taken branch or jump; PC redirect this cycle
- imem_ready  in  1  instruction fetch data valid this cycle
- dmem_busy  in  1  IMEM-stage access outstanding, data not yet returned
- pc_en  out  1  PC register load enable
- if_id_en  out  1  IF/ID register enable
- id_ie_en  out  1  ID/IE register enable
- ie_imem_en  out  1  IE/IMEM register enable
- imem_wb_en  out  1  IMEM/WB register enable
- if_id_flush  out  1  load NOP into IF/ID
- id_ie_flush  out  1  load NOP into ID/IE
- stall_timeout  out  1  sticky watchdog flag

Behaviour:
- Decisions are combinational from the inputs plus registered state, so a stall takes effect in the same cycle. State, counters and `stall_timeout` are registered.
- While `rst` is high: all enables 0, both flushes 1. On the first cycle after reset: state RUN, flush count 0, stall count 0, `stall_timeout` 0.
- States: RUN, FLUSH (remaining-flush counter, 3 bits), MWAIT.
- Priority, highest first, evaluated every cycle:
  1. `dmem_busy`: all enables 0, no flushes; state becomes MWAIT. Any pending flush counter is frozen, not decremented.
  2. `branch_taken`: `pc_en`=1; all stage enables 1; `if_id_flush`=1 and `id_ie_flush`=1. The counter loads FLUSH_CYCLES-1. If that value is nonzero the state becomes FLUSH, otherwise RUN. A `branch_taken` arriving while already in FLUSH reloads the counter.
  3. State FLUSH (counter > 0): `if_id_flush`=1; all enables 1; counter decrements; the state becomes RUN when it reaches 0. Stall requests are ignored here because ID holds a bubble.
  4. `br_stall` or `lu_stall`: `pc_en`=0, `if_id_en`=0, `id_ie_flush`=1; `id_ie_en`, `ie_imem_en`, `imem_wb_en` = 1.
  5. `!imem_ready`: `pc_en`=0, `if_id_flush`=1, all other enables 1.
  6. Otherwise, RUN: all enables 1, no flushes.
- Leaving MWAIT: the first cycle with `dmem_busy`=0 is evaluated normally. If the counter is nonzero, the state returns to FLUSH, else RUN.
- Watchdog:
  - A stall cycle is any cycle with `pc_en`=0 outside reset.
  - The stall counter saturates at MAX_STALL and clears on any cycle with `pc_en`=1.
  - `stall_timeout` is set when the counter reaches MAX_STALL and stays set until `rst`.
- Reset asserted mid-FLUSH or mid-MWAIT: the next cycle after release is RUN with all counters 0.
- A flush and an enable on the same register: the flush wins. The register loads the NOP.

Optional Feature:
- Macro: PIPE_HAZARD_PERF_EN.
- When defined, three extra output ports, all 32-bit, wrapping, cleared by `rst`:
  - `perf_stall_cnt`: counts cycles with `pc_en`=0.
  - `perf_flush_cnt`: counts cycles with `if_id_flush`=1 outside reset.
  - `perf_mwait_cnt`: counts cycles where rule 1 fired.
- When undefined, the ports and counters are absent. The rest of the behaviour is identical.

Decomposition:
- Shared package `core_pkg`:
  - state enum {RUN, FLUSH, MWAIT}
  - stage index constants
  - NOP instruction constant (0x00000013), used by the pipeline registers on flush
- Sub-module `stall_watchdog`: saturating counter plus sticky flag, parameterised by MAX_STALL.
- The remaining priority logic and FSM stay in the top module.

Test Plan:
- Reset release, idle inputs (`imem_ready`=1, all others 0) → cycle 1: all enables 1, flushes 0, `stall_timeout`=0.
- `lu_stall` held for 2 cycles → `pc_en`=`if_id_en`=0 and `id_ie_flush`=1 in both cycles; normal operation in cycle 3.
- `branch_taken` for 1 cycle with FLUSH_CYCLES=3 → cycle 0: both flushes; cycles 1–2: `if_id_flush` only, with `br_stall` asserted but ignored; cycle 3: RUN.
- `branch_taken` then `dmem_busy` for 4 cycles → enables 0 for 4 cycles, counter frozen; the remaining FLUSH cycle completes after `dmem_busy` drops.
- `imem_ready`=0 for 70 cycles with MAX_STALL=64 → `stall_timeout` rises after 64 stall cycles; it remains 1 after `imem_ready` returns; it clears only on `rst`.
- `dmem_busy`, `branch_taken` and `lu_stall` all asserted in the same cycle → all enables 0, no flushes (MWAIT wins). With PIPE_HAZARD_PERF_EN defined, `perf_mwait_cnt` increments by 1.
